alu_issue_unit: RTL and testbench

Sequencing stage that sits directly upstream of the 8-bit ALU in the single-cycle microprocessor datapath. It accepts 16-bit instruction words over a valid/ready handshake and reads two operands from an internal 8×8 register file. It drives the ALU's control, A and B inputs from registers, then captures the ALU result and flags, writes the result back to the destination register and latches the flags into a visible flag register. A host load port and a debug read port give the testbench and top level access to the register file.

---
 rtl/alu_issue_pkg.sv | 45 ++++
 rtl/alu_issue_if.sv | 12 +
 rtl/alu_regfile.sv | 39 +++
 rtl/alu_issue_unit.sv | 110 +++++++++++
 tb/tb_alu_issue_unit.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_issue_pkg.sv
// rtl/alu_issue_pkg.sv - shared types, opcode constants and field positions for the ALU issue stage
package alu_issue_pkg;

  localparam int NREGS = 8;
  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int IW    = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  localparam logic [3:0] OP_ADD      = 4'b0000;
  localparam logic [3:0] OP_SUB      = 4'b0001;
  localparam logic [3:0] OP_MUL      = 4'b0010;
  localparam logic [3:0] OP_RSVD     = 4'b0011;
  localparam logic [1:0] OP_ROT_PFX  = 2'b01;
  localparam logic       OP_GATE_PFX = 1'b1;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 9;
  localparam int RS1_HI = 8;
  localparam int RS1_LO = 6;
  localparam int RS2_HI = 5;
  localparam int RS2_LO = 3;

  // Flag byte is {Q,L,R,M,N,Z,C,V}, MSB first
  localparam int FLG_V = 0;
  localparam int FLG_C = 1;
  localparam int FLG_Z = 2;
  localparam int FLG_N = 3;
  localparam int FLG_M = 4;
  localparam int FLG_R = 5;
  localparam int FLG_L = 6;
  localparam int FLG_Q = 7;

  function automatic logic is_nop(input logic [3:0] op);
    return op == OP_RSVD;
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// rtl/alu_issue_if.sv - instruction valid/ready handshake between producer and issue unit
interface alu_issue_if;
  import alu_issue_pkg::*;

  logic          instr_valid;
  logic          instr_ready;
  logic [IW-1:0] instr;

  modport master (output instr_valid, output instr, input instr_ready);
  modport slave  (input instr_valid, input instr, output instr_ready);

endinterface

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - 8x8 register file, two operand reads, debug read, writeback and host load ports
module alu_regfile
  import alu_issue_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [AW-1:0] i_rs1_addr,
  input  logic [AW-1:0] i_rs2_addr,
  output logic [DW-1:0] o_rs1_data,
  output logic [DW-1:0] o_rs2_data,
  input  logic [AW-1:0] i_dbg_addr,
  output logic [DW-1:0] o_dbg_data,
  input  logic          i_wb_en,
  input  logic [AW-1:0] i_wb_addr,
  input  logic [DW-1:0] i_wb_data,
  input  logic          i_ld_en,
  input  logic [AW-1:0] i_ld_addr,
  input  logic [DW-1:0] i_ld_data
);

  logic [DW-1:0] r_mem [NREGS];

  assign o_rs1_data = r_mem[i_rs1_addr];
  assign o_rs2_data = r_mem[i_rs2_addr];
  assign o_dbg_data = r_mem[i_dbg_addr];

  // Writeback is checked first so it wins over a host load to the same entry
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (i_wb_en && (i_wb_addr == AW'(i)))      r_mem[i] <= i_wb_data;
        else if (i_ld_en && (i_ld_addr == AW'(i))) r_mem[i] <= i_ld_data;
      end
    end
  end

endmodule

// File: rtl/alu_issue_unit.sv
// rtl/alu_issue_unit.sv - accepts instructions, drives ALU inputs, commits result and flags
module alu_issue_unit
  import alu_issue_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst_n,
  alu_issue_if.slave    instr_if,
  input  logic          i_ld_en,
  input  logic [AW-1:0] i_ld_addr,
  input  logic [DW-1:0] i_ld_data,
  input  logic [AW-1:0] i_dbg_addr,
  output logic [DW-1:0] o_dbg_data,
  output logic [3:0]    o_alu_ctl,
  output logic [DW-1:0] o_alu_a,
  output logic [DW-1:0] o_alu_b,
  input  logic [DW-1:0] i_alu_z,
  input  logic [DW-1:0] i_alu_flags,
  output logic          o_res_valid,
  output logic [DW-1:0] o_res_z,
  output logic [DW-1:0] o_flags_reg,
  output logic          o_busy
);

  state_e        r_state, w_state_nxt;
  logic          w_ready, w_accept, w_wb_en;
  logic [AW-1:0] w_rs1, w_rs2, r_rd;
  logic [DW-1:0] w_rs1_data, w_rs2_data;
  logic [3:0]    r_alu_ctl;
  logic [DW-1:0] r_alu_a, r_alu_b, r_res_z, r_flags;

  assign w_rs1 = instr_if.instr[RS1_HI:RS1_LO];
  assign w_rs2 = instr_if.instr[RS2_HI:RS2_LO];

  alu_regfile u_regfile (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_rs1_addr (w_rs1),
    .i_rs2_addr (w_rs2),
    .o_rs1_data (w_rs1_data),
    .o_rs2_data (w_rs2_data),
    .i_dbg_addr (i_dbg_addr),
    .o_dbg_data (o_dbg_data),
    .i_wb_en    (w_wb_en),
    .i_wb_addr  (r_rd),
    .i_wb_data  (i_alu_z),
    .i_ld_en    (i_ld_en),
    .i_ld_addr  (i_ld_addr),
    .i_ld_data  (i_ld_data)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_accept    = 1'b0;
    w_wb_en     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (instr_if.instr_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_wb_en     = !is_nop(r_alu_ctl);
        w_state_nxt = ST_WB;
      end
      ST_WB:   w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ALU inputs reset to the reserved opcode so the downstream ALU idles harmlessly
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_alu_ctl <= OP_RSVD;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_rd      <= '0;
      r_res_z   <= '0;
      r_flags   <= '0;
    end else begin
      if (w_accept) begin
        r_alu_ctl <= instr_if.instr[OPC_HI:OPC_LO];
        r_alu_a   <= w_rs1_data;
        r_alu_b   <= w_rs2_data;
        r_rd      <= instr_if.instr[RD_HI:RD_LO];
      end
      if (r_state == ST_EXEC) begin
        r_res_z <= i_alu_z;
        if (w_wb_en) r_flags <= i_alu_flags;
      end
    end
  end

  assign instr_if.instr_ready = w_ready;
  assign o_alu_ctl   = r_alu_ctl;
  assign o_alu_a     = r_alu_a;
  assign o_alu_b     = r_alu_b;
  assign o_res_z     = r_res_z;
  assign o_flags_reg = r_flags;
  assign o_res_valid = (r_state == ST_WB);
  assign o_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_alu_issue_unit.sv
// tb/tb_alu_issue_unit.sv - self-checking bench for alu_issue_unit with a stand-in ALU and register model
module tb_alu_issue_unit;
  import alu_issue_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ld_en = 1'b0;
  logic [2:0] ld_addr = '0;
  logic [7:0] ld_data = '0;
  logic [2:0] dbg_addr = '0;
  logic [7:0] dbg_data, alu_a, alu_b, alu_z, alu_flags, res_z, flags_reg;
  logic [3:0] alu_ctl;
  logic       res_valid, busy;

  int total = 0;
  int bad   = 0;
  logic [7:0] ref_rf [8];
  logic [7:0] ref_flags;

  always #5 clk = ~clk;

  alu_issue_if ifc ();

  alu_issue_unit dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .instr_if    (ifc.slave),
    .i_ld_en     (ld_en),
    .i_ld_addr   (ld_addr),
    .i_ld_data   (ld_data),
    .i_dbg_addr  (dbg_addr),
    .o_dbg_data  (dbg_data),
    .o_alu_ctl   (alu_ctl),
    .o_alu_a     (alu_a),
    .o_alu_b     (alu_b),
    .i_alu_z     (alu_z),
    .i_alu_flags (alu_flags),
    .o_res_valid (res_valid),
    .o_res_z     (res_z),
    .o_flags_reg (flags_reg),
    .o_busy      (busy)
  );

  function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] t;
    if (op == OP_ADD)                return a + b;
    if (op == OP_SUB)                return a - b;
    if (op == OP_MUL)                return a * b;
    if (op == OP_RSVD)               return 8'h00;
    if (op[3:2] == OP_ROT_PFX) begin
      t = {a, a} << b[2:0];
      return t[15:8];
    end
    return a ^ b;
  endfunction

  function automatic logic [7:0] flg_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] f, r;
    logic [8:0] s;
    if (op == OP_RSVD) return 8'hA5;
    r = alu_f(op, a, b);
    f = '0;
    f[FLG_Z] = (r == 8'h00);
    f[FLG_N] = r[7];
    f[FLG_Q] = ^r;
    f[FLG_M] = (a > b);
    f[FLG_L] = a[7];
    f[FLG_R] = b[0];
    if (op == OP_ADD) begin
      s = {1'b0, a} + {1'b0, b};
      f[FLG_C] = s[8];
      f[FLG_V] = (a[7] == b[7]) && (r[7] != a[7]);
    end else if (op == OP_SUB) begin
      f[FLG_C] = (a < b);
    end
    return f;
  endfunction

  assign alu_z     = alu_f(alu_ctl, alu_a, alu_b);
  assign alu_flags = flg_f(alu_ctl, alu_a, alu_b);

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rf();
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1 chk($sformatf("rf[%0d]", i), dbg_data, ref_rf[i]);
    end
  endtask

  task automatic host_load(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
    ref_rf[a] = d;
    dbg_addr = a;
    #1 chk("host_load", dbg_data, d);
  endtask

  // ph: 0 no host load, 1 load on the acceptance edge, 2 load on the writeback edge
  task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input int ph, input logic [2:0] la, input logic [7:0] ld);
    logic [7:0] ea, eb, ez;
    @(negedge clk);
    chk("ready_idle", ifc.instr_ready, 1'b1);
    ifc.instr_valid = 1'b1;
    ifc.instr = {op, rd, rs1, rs2, 3'b000};
    ea = ref_rf[rs1];
    eb = ref_rf[rs2];
    if (ph == 1) begin
      ld_en = 1'b1; ld_addr = la; ld_data = ld;
      ref_rf[la] = ld;
    end
    @(negedge clk);
    ifc.instr_valid = 1'b0;
    ld_en = 1'b0;
    chk("exec_ctl", alu_ctl, op);
    chk("exec_a", alu_a, ea);
    chk("exec_b", alu_b, eb);
    chk("exec_busy", busy, 1'b1);
    chk("exec_ready", ifc.instr_ready, 1'b0);
    chk("exec_resv", res_valid, 1'b0);
    ez = alu_f(op, ea, eb);
    if (ph == 2) begin
      ld_en = 1'b1; ld_addr = la; ld_data = ld;
      ref_rf[la] = ld;
    end
    if (op != OP_RSVD) begin
      ref_rf[rd] = ez;
      ref_flags = flg_f(op, ea, eb);
    end
    @(negedge clk);
    ld_en = 1'b0;
    chk("wb_resv", res_valid, 1'b1);
    chk("wb_res_z", res_z, ez);
    chk("wb_flags", flags_reg, ref_flags);
    chk("wb_ctl_hold", alu_ctl, op);
    dbg_addr = rd;
    #1 chk("wb_rd", dbg_data, ref_rf[rd]);
    if (ph != 0) begin
      dbg_addr = la;
      #1 chk("wb_ld", dbg_data, ref_rf[la]);
    end
    @(negedge clk);
    chk("idle_resv", res_valid, 1'b0);
    chk("idle_ready", ifc.instr_ready, 1'b1);
    chk("idle_busy", busy, 1'b0);
    chk("idle_a_hold", alu_a, ea);
  endtask

  initial begin
    ifc.instr_valid = 1'b0;
    ifc.instr = '0;
    for (int i = 0; i < 8; i++) ref_rf[i] = 8'h00;
    ref_flags = 8'h00;

    repeat (2) @(negedge clk);
    chk("rst_ctl", alu_ctl, OP_RSVD);
    chk("rst_a", alu_a, 8'h00);
    chk("rst_b", alu_b, 8'h00);
    chk("rst_res_z", res_z, 8'h00);
    chk("rst_flags", flags_reg, 8'h00);
    chk("rst_resv", res_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", ifc.instr_ready, 1'b1);
    chk_rf();

    host_load(3'd1, 8'h05);
    host_load(3'd2, 8'h03);
    issue(OP_ADD, 3'd3, 3'd1, 3'd2, 0, 3'd0, 8'h00);

    // Dependent pair with valid held high: second acceptance lands 3 cycles after the first
    @(negedge clk);
    ifc.instr_valid = 1'b1;
    ifc.instr = {OP_ADD, 3'd3, 3'd1, 3'd2, 3'b000};
    @(negedge clk);
    chk("b2b_a1", alu_a, 8'h05);
    ifc.instr = {OP_ADD, 3'd4, 3'd3, 3'd3, 3'b000};
    @(negedge clk);
    chk("b2b_wb1", res_valid, 1'b1);
    @(negedge clk);
    chk("b2b_idle", busy, 1'b0);
    @(negedge clk);
    ifc.instr_valid = 1'b0;
    chk("b2b_busy2", busy, 1'b1);
    chk("b2b_a2", alu_a, 8'h08);
    chk("b2b_b2", alu_b, 8'h08);
    @(negedge clk);
    chk("b2b_res2", res_z, 8'h10);
    ref_rf[3] = 8'h08;
    ref_rf[4] = 8'h10;
    ref_flags = flg_f(OP_ADD, 8'h08, 8'h08);
    chk("b2b_flags2", flags_reg, ref_flags);
    dbg_addr = 3'd4;
    #1 chk("b2b_r4", dbg_data, 8'h10);
    @(negedge clk);

    host_load(3'd1, 8'h03);
    host_load(3'd2, 8'h05);
    issue(OP_SUB, 3'd3, 3'd1, 3'd2, 0, 3'd0, 8'h00);
    chk("sub_r3", ref_rf[3], 8'hFE);
    issue(OP_RSVD, 3'd1, 3'd2, 3'd2, 0, 3'd0, 8'h00);

    host_load(3'd1, 8'h05);
    host_load(3'd2, 8'h03);
    issue(OP_ADD, 3'd3, 3'd1, 3'd2, 2, 3'd3, 8'hAA);
    issue(OP_ADD, 3'd3, 3'd1, 3'd2, 2, 3'd5, 8'hAA);
    issue(OP_ADD, 3'd6, 3'd1, 3'd2, 1, 3'd1, 8'h77);
    chk_rf();

    // Reset while in EXEC aborts the instruction and clears everything
    @(negedge clk);
    ifc.instr_valid = 1'b1;
    ifc.instr = {OP_ADD, 3'd7, 3'd1, 3'd2, 3'b000};
    @(negedge clk);
    ifc.instr_valid = 1'b0;
    chk("mid_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_resv", res_valid, 1'b0);
    chk("mid_rst_ctl", alu_ctl, OP_RSVD);
    chk("mid_rst_a", alu_a, 8'h00);
    chk("mid_rst_b", alu_b, 8'h00);
    chk("mid_rst_res_z", res_z, 8'h00);
    chk("mid_rst_flags", flags_reg, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_resv", res_valid, 1'b0);
    chk("post_rst_ready", ifc.instr_ready, 1'b1);
    for (int i = 0; i < 8; i++) ref_rf[i] = 8'h00;
    ref_flags = 8'h00;
    chk_rf();
    host_load(3'd1, 8'h21);
    issue(OP_ADD, 3'd7, 3'd1, 3'd1, 0, 3'd0, 8'h00);

    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 1) == 1) host_load(3'($urandom_range(0, 7)), 8'($urandom));
      issue(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), int'($urandom_range(0, 2)), 3'($urandom_range(0, 7)), 8'($urandom));
    end
    chk_rf();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
